out_port_fifo: RTL and testbench

- Parametrised successor to the single-register CPU output port.
- Captures values driven on the datapath bus when the `OutportIn` strobe is asserted, and queues them in a DEPTH-entry FIFO.
- Presents the queued values to an external device over a valid/ready handshake.
- Keeps a held copy of the last delivered value for static displays (LEDs, seven-segment), plus status and a sticky overflow flag for the control unit.

---
 rtl/out_port_pkg.sv | 21 ++
 rtl/out_port_fifo_if.sv | 23 ++
 rtl/out_port_fifo_mem.sv | 30 +++
 rtl/out_port_fifo.sv | 113 +++++++++++
 tb/tb_out_port_fifo.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/out_port_pkg.sv
// Shared definitions for the output-port FIFO: default sizing, the
// per-cycle operation encoding and the occupancy-count width helper.
package out_port_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    // What the FIFO does on a given clock edge, built as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/out_port_fifo_if.sv
// Valid/ready handshake between the output-port FIFO and the external
// device. The FIFO side is the master; the device side is the slave.
interface out_port_fifo_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/out_port_fifo_mem.sv
// Storage array for the output-port FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module out_port_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the head entry falls through immediately.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/out_port_fifo.sv
// Output port FIFO: captures datapath bus values on the OutportIn strobe,
// queues them, hands them to a device over valid/ready and keeps a held
// copy of the last delivered value plus status and a sticky overflow flag.
module out_port_fifo
    import out_port_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW   = count_width(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             OutportIn,
    input  logic [WIDTH-1:0] BusMuxOut,
    out_port_fifo_if.master  dev,
    output logic [WIDTH-1:0] out_hold,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [WIDTH-1:0] head;
    logic             pop;
    logic             push;
    logic             drop;
    fifo_op_e         op;

    // Status flags come from the count only; pointer equality is ambiguous
    // once the pointers wrap.
    always_comb begin
        full  = (count == COUNT_MAX);
        empty = (count == '0);
    end

    // Handshake decode. out_valid depends on state only, never on out_ready.
    // A push into a full FIFO is still accepted when a pop frees a slot.
    always_comb begin
        dev.out_valid = ~empty;
        dev.out_data  = empty ? '0 : head;
        pop           = ~empty & dev.out_ready;
        push          = OutportIn & (~full | pop);
        drop          = OutportIn & full & ~pop;
        op            = fifo_op_e'({push, pop});
    end

    out_port_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr),
        .wdata (BusMuxOut),
        .raddr (rptr),
        .rdata (head)
    );

    // Pointers advance on their own operation and wrap naturally.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
        end
    end

    // Occupancy only moves when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count <= '0;
        end else begin
            case (op)
                OP_PUSH: count <= count + CW'(1);
                OP_POP:  count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Held copy of the most recently delivered value for static displays.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            out_hold <= '0;
        end else if (pop) begin
            out_hold <= head;
        end
    end

    // Sticky overflow; a dropped push outranks a same-cycle clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_out_port_fifo.sv
// Self-checking bench for out_port_fifo: a vector table for the basic
// transfer/fill/overflow flow, a scoreboard queue for delivered data, and
// hand-written sequences for the multi-cycle corner cases.
module tb_out_port_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk       = 1'b0;
    logic             clr       = 1'b0;
    logic             OutportIn = 1'b0;
    logic             ovf_clr   = 1'b0;
    logic [WIDTH-1:0] BusMuxOut = '0;
    logic [WIDTH-1:0] out_hold;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             overflow;

    out_port_fifo_if #(.WIDTH(WIDTH)) bus ();

    out_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .OutportIn (OutportIn),
        .BusMuxOut (BusMuxOut),
        .dev       (bus),
        .out_hold  (out_hold),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        ready;
        logic        clr_ovf;
        int          exp_count;
        logic        exp_ovf;
        logic [31:0] exp_hold;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] sb [$];
    logic [31:0] m_hold;
    logic        m_ovf;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, predict the
    // handshake from the model, then advance to the next falling edge.
    task automatic applyStimulus(input logic push, input logic [31:0] data,
                                 input logic ready, input logic oclr);
        logic        pop_m;
        logic [31:0] exp;
        OutportIn     = push;
        BusMuxOut     = data;
        bus.out_ready = ready;
        ovf_clr       = oclr;
        #1;
        cmp("valid_pre", 32'(bus.out_valid), 32'(sb.size() != 0));
        pop_m = (sb.size() != 0) && ready;
        if (pop_m) begin
            exp = sb.pop_front();
            cmp("sb_data", bus.out_data, exp);
            m_hold = exp;
        end
        if (push) begin
            if (sb.size() < DEPTH) begin
                sb.push_back(data);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!(push && sb.size() >= DEPTH && !pop_m) && oclr && !(push && !pop_m && sb.size() == DEPTH && 0)) begin
            if (!(push && m_ovf && !pop_m && sb.size() == DEPTH)) begin
                m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        OutportIn     = 1'b0;
        ovf_clr       = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    // Compare every observable output with the model state.
    task automatic checkOutput();
        cmp("count", 32'(count), 32'(sb.size()));
        cmp("empty", 32'(empty), 32'(sb.size() == 0));
        cmp("full", 32'(full), 32'(sb.size() == DEPTH));
        cmp("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
        cmp("out_hold", out_hold, m_hold);
        cmp("overflow", 32'(overflow), 32'(m_ovf));
        if (sb.size() != 0) begin
            cmp("head", bus.out_data, sb[0]);
        end else begin
            cmp("head_gated", bus.out_data, 32'h0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h1, 1'b0, 1'b0, 1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b0, 32'h1};
        vecs[2]  = '{1'b1, 32'h1, 1'b0, 1'b0, 1, 1'b0, 32'h1};
        vecs[3]  = '{1'b1, 32'h2, 1'b0, 1'b0, 2, 1'b0, 32'h1};
        vecs[4]  = '{1'b1, 32'h3, 1'b0, 1'b0, 3, 1'b0, 32'h1};
        vecs[5]  = '{1'b1, 32'h4, 1'b0, 1'b0, 4, 1'b0, 32'h1};
        vecs[6]  = '{1'b1, 32'h5, 1'b0, 1'b0, 4, 1'b1, 32'h1};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 3, 1'b1, 32'h1};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b0, 2, 1'b1, 32'h2};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1, 1'b1, 32'h3};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1, 32'h4};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 0, 1'b1, 32'h4};
        vecs[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 0, 1'b0, 32'h4};

        m_hold        = '0;
        m_ovf         = 1'b0;
        bus.out_ready = 1'b0;

        // Power-up reset is visible before any clock edge.
        #1;
        checkOutput();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        // Single transfer, fill to full with a dropped push, drain.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, vecs[i].ready, vecs[i].clr_ovf);
            checkOutput();
            cmp($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            cmp($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            cmp($sformatf("tbl%0d_hold", i), out_hold, vecs[i].exp_hold);
        end

        // Push and ready together while empty: no bypass, held value kept.
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
        checkOutput();
        cmp("empty_push_hold", out_hold, 32'h4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput();

        // Full FIFO with push and pop in the same cycle.
        for (int v = 10; v < 14; v++) begin
            applyStimulus(1'b1, 32'(v), 1'b0, 1'b0);
        end
        checkOutput();
        applyStimulus(1'b1, 32'd14, 1'b1, 1'b0);
        checkOutput();
        cmp("both_count", 32'(count), 32'd4);
        cmp("both_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput();
        cmp("both_hold", out_hold, 32'd14);

        // Pointer wrap-around over many rounds.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b1, 32'(100 + r * 3 + k), 1'b0, 1'b0);
            end
            for (int k = 0; k < 3; k++) begin
                applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
            end
            cmp("wrap_count", 32'(count), 32'd0);
        end
        checkOutput();

        // Overflow set beats a same-cycle clear; a lone clear wins later.
        for (int v = 200; v < 204; v++) begin
            applyStimulus(1'b1, 32'(v), 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'd204, 1'b0, 1'b1);
        checkOutput();
        cmp("ovf_set_wins", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput();
        cmp("ovf_cleared", 32'(overflow), 32'd0);

        // Asynchronous reset mid-cycle with data still queued.
        applyStimulus(1'b1, 32'd205, 1'b1, 1'b0);
        cmp("pre_reset_hold", out_hold, 32'd200);
        #2;
        clr = 1'b0;
        #1;
        cmp("rst_count", 32'(count), 32'd0);
        cmp("rst_empty", 32'(empty), 32'd1);
        cmp("rst_full", 32'(full), 32'd0);
        cmp("rst_valid", 32'(bus.out_valid), 32'd0);
        cmp("rst_hold", out_hold, 32'd0);
        cmp("rst_ovf", 32'(overflow), 32'd0);
        sb.delete();
        m_hold = '0;
        m_ovf  = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        applyStimulus(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
